// File: rtl/wb_master_ctrl_if.sv
// wb_master_ctrl_if: Wishbone B3 classic bus between one master and its slave side
interface wb_master_ctrl_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/wb_master_ctrl.sv
// wb_master_ctrl: single-transfer Wishbone B3 master with retry, error status and
// an optional REQ timeout enabled by WB_MASTER_TIMEOUT_EN.
module wb_master_ctrl #(
  parameter int RETRY_MAX = 3,
  parameter int TIMEOUT   = 256
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic                    start,
  input  logic [31:0]             address,
  input  logic [3:0]              selection,
  input  logic                    write,
  input  logic [31:0]             data_wr,
  output logic                    active,
  output logic                    done,
  output logic                    error,
  output logic [31:0]             data_rd,
  wb_master_ctrl_if.master        wb
);
  localparam int RW = RETRY_MAX > 0 ? $clog2(RETRY_MAX + 1) : 1;
  typedef enum logic [1:0] {IDLE, REQ, BACKOFF} state_t;
  state_t state, state_d;
  logic [RW-1:0] retry_cnt;
  logic accept, ack_ok, retry, fail, finish, tmo;
  logic cyc_d, we_d, error_d;
  logic [31:0] adr_d, dat_d, rd_d;
  logic [3:0] sel_d;
`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) > 8 ? $clog2(TIMEOUT) : 8;
  logic [TW-1:0] tmo_cnt;
  assign tmo = state == REQ && !(wb.wb_ack_i || wb.wb_err_i || wb.wb_rty_i) && tmo_cnt == TW'(TIMEOUT - 1);
  always_ff @(posedge wb_clk)
    if (wb_rst || (state_d == REQ && state != REQ)) tmo_cnt <= '0;
    else if (state == REQ) tmo_cnt <= tmo_cnt + 1'b1;
`else
  // no timeout in this build; TIMEOUT only keeps the parameter list uniform
  assign tmo = TIMEOUT < 0;
`endif
  always_comb begin
    accept = state == IDLE && start;
    ack_ok = state == REQ && !wb.wb_err_i && wb.wb_ack_i;
    retry  = state == REQ && !wb.wb_err_i && !wb.wb_ack_i && wb.wb_rty_i && retry_cnt < RW'(RETRY_MAX);
    fail   = state == REQ && (wb.wb_err_i || tmo ||
             (!wb.wb_ack_i && wb.wb_rty_i && retry_cnt >= RW'(RETRY_MAX)));
    finish = ack_ok || fail;
  end
  always_ff @(posedge wb_clk)
    state <= wb_rst ? IDLE : state_d;
  always_comb
    state_d = state == IDLE    ? (start ? REQ : IDLE) :
              state == BACKOFF ? REQ :
              finish           ? IDLE :
              retry            ? BACKOFF : REQ;
  always_ff @(posedge wb_clk)
    if (wb_rst || accept) retry_cnt <= '0;
    else if (retry) retry_cnt <= retry_cnt + 1'b1;
  // next values of the registered outputs; cyc/stb simply follow "next state is REQ"
  always_comb begin
    cyc_d   = state_d == REQ;
    we_d    = accept ? write : finish ? 1'b0 : wb.wb_we_o;
    adr_d   = accept ? address : wb.wb_adr_o;
    dat_d   = accept ? data_wr : wb.wb_dat_o;
    sel_d   = accept ? selection : wb.wb_sel_o;
    error_d = accept ? 1'b0 : finish ? fail : error;
    rd_d    = ack_ok && !wb.wb_we_o ? wb.wb_dat_i : data_rd;
  end
  always_ff @(posedge wb_clk)
    if (wb_rst) begin
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
      wb.wb_sel_o <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      data_rd     <= '0;
    end else begin
      wb.wb_cyc_o <= cyc_d;
      wb.wb_stb_o <= cyc_d;
      wb.wb_we_o  <= we_d;
      wb.wb_adr_o <= adr_d;
      wb.wb_dat_o <= dat_d;
      wb.wb_sel_o <= sel_d;
      done        <= finish;
      error       <= error_d;
      data_rd     <= rd_d;
    end
  assign active = state != IDLE;
endmodule

// File: tb/tb_wb_master_ctrl.sv
// tb_wb_master_ctrl: directed transfers against a transaction-level timeline model,
// checked every cycle, plus literal pins on key results.
module tb_wb_master_ctrl;
  localparam int RETRY_MAX = 3;
  localparam int TIMEOUT = 16;
  logic wb_clk = 1'b0;
  logic wb_rst, start, write, active, done, error;
  logic [31:0] address, data_wr, data_rd;
  logic [3:0] selection;
  wb_master_ctrl_if bus();
  wb_master_ctrl #(.RETRY_MAX(RETRY_MAX), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .address(address),
    .selection(selection), .write(write), .data_wr(data_wr), .active(active),
    .done(done), .error(error), .data_rd(data_rd), .wb(bus)
  );
  always #5 wb_clk = ~wb_clk;
  typedef struct packed {
    logic cyc, act, done, err, we;
    logic [31:0] rd;
    logic [2:0] rsp;
  } ent_t;
  ent_t exp_e, tl[$];
  logic [2:0] scr[$];
  logic [31:0] m_adr, m_dat, m_rd;
  logic [3:0] m_sel;
  logic m_err, chk_en, pin_en;
  string pin_name;
  logic [31:0] pin_got, pin_exp;
  int n_chk = 0, n_err = 0, n_done = 0, n_act = 0, n_req = 0, n_bo = 0;
  logic prev_cyc = 1'b0;
  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, got, want);
    end
  endtask
  always @(negedge wb_clk) begin
    if (chk_en) begin
      cmp("cyc", 32'(bus.wb_cyc_o), 32'(exp_e.cyc));
      cmp("stb", 32'(bus.wb_stb_o), 32'(exp_e.cyc));
      cmp("we", 32'(bus.wb_we_o), 32'(exp_e.we));
      cmp("active", 32'(active), 32'(exp_e.act));
      cmp("done", 32'(done), 32'(exp_e.done));
      cmp("error", 32'(error), 32'(exp_e.err));
      cmp("data_rd", data_rd, exp_e.rd);
      cmp("adr", bus.wb_adr_o, m_adr);
      cmp("dat_o", bus.wb_dat_o, m_dat);
      cmp("sel", 32'(bus.wb_sel_o), 32'(m_sel));
    end
    if (pin_en) cmp(pin_name, pin_got, pin_exp);
    if (done) n_done++;
    if (active) n_act++;
    if (bus.wb_cyc_o && !prev_cyc) n_req++;
    if (active && !bus.wb_cyc_o) n_bo++;
    prev_cyc = bus.wb_cyc_o;
  end
  task automatic pin(input string nm, input logic [31:0] got, input logic [31:0] want);
    pin_name = nm; pin_got = got; pin_exp = want; pin_en = 1'b1;
    @(negedge wb_clk); #1 pin_en = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge wb_clk); #1;
      start = 1'b0;
      {bus.wb_rty_i, bus.wb_err_i, bus.wb_ack_i} = 3'd0;
      exp_e = '{1'b0, 1'b0, 1'b0, m_err, 1'b0, m_rd, 3'd0};
    end
  endtask
  // Model: each script code is the slave response during one REQ cycle
  // ({rty,err,ack}); err wins, then ack, then rty; every retry costs one backoff cycle.
  task automatic run_txn(input logic [31:0] a, input logic [3:0] s, input logic w,
                         input logic [31:0] d, input logic [31:0] rdat,
                         input int rst_at, input int junk_at);
    int retries;
    logic fin, fail;
    logic [2:0] c;
`ifdef WB_MASTER_TIMEOUT_EN
    int waits;
    waits = 0;
`endif
    retries = 0; fin = 1'b0; fail = 1'b0;
    tl.delete();
    for (int i = 0; i < scr.size() && !fin; i++) begin
      c = scr[i];
      tl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, w, m_rd, c});
      if (c[1]) begin fin = 1'b1; fail = 1'b1; end
      else if (c[0]) fin = 1'b1;
      else if (c[2]) begin
        if (retries < RETRY_MAX) begin
          retries++;
`ifdef WB_MASTER_TIMEOUT_EN
          waits = 0;
`endif
          tl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, w, m_rd, 3'd0});
        end else begin fin = 1'b1; fail = 1'b1; end
      end else begin
`ifdef WB_MASTER_TIMEOUT_EN
        waits++;
        if (waits == TIMEOUT) begin fin = 1'b1; fail = 1'b1; end
`endif
      end
    end
    if (fin) tl.push_back('{1'b0, 1'b0, 1'b1, fail, 1'b0, (!fail && !w) ? rdat : m_rd, 3'd0});
    address = a; selection = s; write = w; data_wr = d; start = 1'b1;
    for (int i = 0; i < tl.size(); i++) begin
      @(posedge wb_clk); #1;
      if (i == 0) begin m_adr = a; m_dat = d; m_sel = s; end
      start = i == junk_at;
      address = ~a; selection = ~s; write = ~w; data_wr = ~d;
      exp_e = tl[i];
      wb_rst = i == rst_at;
      {bus.wb_rty_i, bus.wb_err_i, bus.wb_ack_i} = wb_rst ? 3'd0 : tl[i].rsp;
      bus.wb_dat_i = tl[i].rsp[0] ? rdat : 32'hBAD0_F00D;
      if (i == rst_at) break;
    end
    if (rst_at >= 0 && rst_at < tl.size()) begin
      @(posedge wb_clk); #1;
      wb_rst = 1'b0; start = 1'b0;
      {bus.wb_rty_i, bus.wb_err_i, bus.wb_ack_i} = 3'd0;
      m_adr = '0; m_dat = '0; m_sel = '0; m_rd = '0; m_err = 1'b0;
      exp_e = '0;
    end else if (fin) begin
      m_rd = tl[tl.size()-1].rd;
      m_err = tl[tl.size()-1].err;
    end
  endtask
  int s_done, s_act, s_req, s_bo;
  task automatic snap();
    s_done = n_done; s_act = n_act; s_req = n_req; s_bo = n_bo;
  endtask
  initial begin
    wb_rst = 1'b1; start = 1'b0; address = '0; selection = '0; write = 1'b0; data_wr = '0;
    bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
    chk_en = 1'b0; pin_en = 1'b0; exp_e = '0; pin_name = ""; pin_got = '0; pin_exp = '0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_rd = '0; m_err = 1'b0;
    @(posedge wb_clk); #1 chk_en = 1'b1;
    @(posedge wb_clk); #1 wb_rst = 1'b0;
    idle(2);
    scr = '{3'd1};
    run_txn(32'h0000_0020, 4'hF, 1'b0, 32'h0, 32'hDEAD_BEEF, -1, -1);
    idle(2);
    pin("rd_data", data_rd, 32'hDEAD_BEEF);
    snap();
    scr = '{3'd0, 3'd0, 3'd1};
    run_txn(32'h0000_0010, 4'hF, 1'b1, 32'h1234_5678, 32'h0BAD_0BAD, -1, -1);
    idle(2);
    pin("wr_done_pulses", 32'(n_done - s_done), 32'd1);
    pin("wr_active_cycles", 32'(n_act - s_act), 32'd3);
    pin("wr_keeps_data_rd", data_rd, 32'hDEAD_BEEF);
    snap();
    scr = '{3'd1};
    run_txn(32'h0000_0040, 4'h3, 1'b0, 32'h0, 32'hCAFE_0001, -1, -1);
    run_txn(32'h0000_0044, 4'hC, 1'b0, 32'h0, 32'hCAFE_0002, -1, -1);
    idle(2);
    pin("b2b_done_pulses", 32'(n_done - s_done), 32'd2);
    pin("b2b_active_cycles", 32'(n_act - s_act), 32'd2);
    pin("b2b_data_rd", data_rd, 32'hCAFE_0002);
    snap();
    scr = '{3'd4, 3'd4, 3'd1};
    run_txn(32'h0000_0050, 4'h5, 1'b1, 32'hA5A5_0050, 32'h0, -1, -1);
    idle(2);
    pin("rty2_backoffs", 32'(n_bo - s_bo), 32'd2);
    pin("rty2_requests", 32'(n_req - s_req), 32'd3);
    pin("rty2_error", 32'(error), 32'd0);
    snap();
    scr = '{3'd4, 3'd4, 3'd4, 3'd4};
    run_txn(32'h0000_0060, 4'hF, 1'b0, 32'h0, 32'h6666_6666, -1, -1);
    idle(2);
    pin("rty4_requests", 32'(n_req - s_req), 32'd4);
    pin("rty4_done", 32'(n_done - s_done), 32'd1);
    pin("rty4_error", 32'(error), 32'd1);
    scr = '{3'd0, 3'd3};
    run_txn(32'h0000_0070, 4'hF, 1'b0, 32'h0, 32'h1111_1111, -1, -1);
    idle(2);
    pin("ackerr_error", 32'(error), 32'd1);
    pin("ackerr_data_rd", data_rd, 32'hCAFE_0002);
    scr = '{3'd5};
    run_txn(32'h0000_0074, 4'hF, 1'b0, 32'h0, 32'h7777_0074, -1, -1);
    idle(2);
    pin("ackrty_data_rd", data_rd, 32'h7777_0074);
    pin("ackrty_error", 32'(error), 32'd0);
    snap();
    scr.delete();
    for (int i = 0; i < 1000; i++) scr.push_back(3'd0);
    run_txn(32'h0000_0080, 4'hF, 1'b0, 32'h0, 32'h8888_8888, 999, -1);
    idle(2);
`ifdef WB_MASTER_TIMEOUT_EN
    pin("tmo_done", 32'(n_done - s_done), 32'd1);
    pin("tmo_req_cycles", 32'(n_act - s_act), 32'd16);
    pin("tmo_error", 32'(error), 32'd1);
`else
    pin("hang_done", 32'(n_done - s_done), 32'd0);
    pin("hang_active_cycles", 32'(n_act - s_act), 32'd1000);
`endif
    snap();
    scr = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    run_txn(32'h0000_0090, 4'h6, 1'b0, 32'h0, 32'h9999_9999, 3, 1);
    idle(3);
    pin("rst_no_done", 32'(n_done - s_done), 32'd0);
    pin("rst_requests", 32'(n_req - s_req), 32'd1);
    pin("rst_data_rd", data_rd, 32'h0);
    scr = '{3'd0, 3'd1};
    run_txn(32'h0000_00A0, 4'hF, 1'b0, 32'h0, 32'h5A5A_5A5A, -1, -1);
    idle(2);
    pin("post_rst_data_rd", data_rd, 32'h5A5A_5A5A);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
